alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter RES_LAT, default 1: the number of cycles after the issue cycle before alu_out is captured (range 1-4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req_valid (input, 1), req_ready (output, 1), req_a (input, 16), req_b (input, 16), req_fun (input, 4): the command request channel.
REQ-005 The block SHALL have ports alu_a (output, 16), alu_b (output, 16), alu_fun (output, 4): the operand/function drive to the 16-bit ALU.
REQ-006 The block SHALL have ports alu_out (input, 16), arith_flag, logic_flag, cmp_flag and shift_flag (inputs, 1 each): the ALU result (registered, one clk) and its combinational class flags.
REQ-007 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 16), rsp_class (output, 2), rsp_err (output, 2): the response channel.
REQ-008 The block SHALL have port cmd_count, output, 16 bits: the number of completed responses.

Function
REQ-009 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-010 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-011 A request SHALL be accepted on a clk edge with req_valid=1 in IDLE; req_a, req_b and req_fun are latched on that edge.
REQ-012 The expected class SHALL be decoded from fun as: 0-3 -> 00 (arith), 4-9 -> 01 (logic), 10-12 -> 10 (cmp), 13-14 -> 11 (shift).
REQ-013 A request with fun=4'hF SHALL go IDLE->RESP with rsp_err=01, rsp_data=0 and rsp_class=00.
REQ-014 A request with fun=4'h3 and b=0 SHALL go IDLE->RESP with rsp_err=10, rsp_data=0 and rsp_class=00.
REQ-015 All other accepted requests SHALL go IDLE->ISSUE.
REQ-016 In ISSUE and WAIT, alu_a, alu_b and alu_fun SHALL drive the latched operands and function; in IDLE and RESP they SHALL drive 0, 0 and 4'hF.
REQ-017 At the end of ISSUE, the block SHALL sample the four flags, then go to WAIT.
REQ-018 If the sampled flags are not exactly one-hot, or do not match the expected class, the response SHALL carry rsp_err=11.
REQ-019 WAIT SHALL last RES_LAT cycles, counted by an internal counter.
REQ-020 On the last WAIT edge, alu_out SHALL be captured into rsp_data, and the FSM SHALL go to RESP.
REQ-021 For non-error requests, rsp_class SHALL be the expected class and rsp_err SHALL be 00.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_class and rsp_err SHALL be held stable until an edge with rsp_ready=1.
REQ-023 On an edge in RESP with rsp_ready=1, the FSM SHALL go to IDLE and cmd_count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-024 Latency for a valid command SHALL be: rsp_valid first high 2+RES_LAT cycles after the accept edge.
REQ-025 Latency for an error command SHALL be: rsp_valid first high 1 cycle after the accept edge.
REQ-026 No new request SHALL be accepted in the cycle in which a response completes; the next accept is possible one cycle later, in IDLE.
REQ-027 req_valid SHALL be ignored outside IDLE, with no queuing.
REQ-028 rsp_valid SHALL be 0 outside RESP, and rsp_data, rsp_class and rsp_err SHALL retain their last values there.

Reset
REQ-029 While rst=1, the block SHALL immediately force state IDLE and req_ready=0.
REQ-030 While rst=1, the block SHALL force rsp_valid=0, rsp_data=0, rsp_class=00, rsp_err=00 and cmd_count=0.
REQ-031 While rst=1, the block SHALL force alu_a=0, alu_b=0, alu_fun=4'hF, and clear all latched operands and the WAIT counter.
REQ-032 Reset asserted in any state SHALL abort the in-flight command without a response and without incrementing cmd_count.
REQ-033 After rst deasserts, req_ready SHALL be 1 from the first clk edge.

Verification
REQ-034 The bench SHALL cover: RES_LAT=1, fun=0000, a=0x0003, b=0x0004, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_data=0x0007, class=00, err=00, cmd_count=1.
REQ-035 The bench SHALL cover: fun=0011, a=0x0010, b=0x0000 -> rsp_valid 1 cycle after accept, rsp_data=0, err=10, alu_fun stays 4'hF throughout.
REQ-036 The bench SHALL cover: fun=1111 -> err=01, rsp_data=0; then fun=1010, a=b=0x1234 -> rsp_data=0x0001, class=10, err=00.
REQ-037 The bench SHALL cover: ALU model forcing cmp_flag=1 for fun=0100 -> rsp_err=11, class=01.
REQ-038 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP with req_valid=1 -> outputs stable, req_ready=0, no second accept, cmd_count unchanged until release.
REQ-039 The bench SHALL cover: rst pulsed mid-WAIT -> state IDLE, rsp_valid=0, cmd_count=0, alu_fun=4'hF, then a fresh add completes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: takes one ALU command at a time from a valid/ready
// request channel, drives it into an external 16-bit ALU, checks the ALU
// class flags against the class expected from the function code, captures
// the result RES_LAT cycles later and returns it on a valid/ready
// response channel.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_a, req_b, req_fun          request operands and function code
//   alu_a, alu_b, alu_fun          operand/function drive to the ALU
//   alu_out                        ALU result (registered inside the ALU)
//   arith/logic/cmp/shift_flag     ALU combinational class flags
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_class, rsp_err   response payload
//   cmd_count                      completed responses, wraps at 16 bits
module alu_cmd_sequencer #(
  parameter int unsigned RES_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_fun,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_fun,
  input  logic [15:0] alu_out,
  input  logic        arith_flag,
  input  logic        logic_flag,
  input  logic        cmp_flag,
  input  logic        shift_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_class,
  output logic [1:0]  rsp_err,
  output logic [15:0] cmd_count
);

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 3;

  localparam logic [FW-1:0] FUN_NOP = 4'hF;
  localparam logic [FW-1:0] FUN_DIV = 4'h3;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_FUN   = 2'b01;
  localparam logic [1:0] ERR_DIV0  = 2'b10;
  localparam logic [1:0] ERR_FLAGS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            req_ready_q;
  logic [FW-1:0]   fun_q;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [FW-1:0]   alu_fun_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            flag_err_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic [1:0]      rsp_class_q;
  logic [1:0]      rsp_err_q;
  logic [DW-1:0]   cmd_count_q;

  logic [3:0]      flags_c;
  logic [1:0]      exp_class_c;
  logic            flag_err_c;

  // Expected result class of a function code.
  function automatic logic [1:0] class_of(input logic [FW-1:0] f);
    logic [1:0] c;
    if (f <= 4'd3)       c = 2'b00;
    else if (f <= 4'd9)  c = 2'b01;
    else if (f <= 4'd12) c = 2'b10;
    else                 c = 2'b11;
    return c;
  endfunction

  // Flag check: the flags must equal the one-hot code of the expected class,
  // which rejects both multi/zero-hot patterns and a wrong class.
  always_comb begin
    flags_c     = {shift_flag, cmp_flag, logic_flag, arith_flag};
    exp_class_c = class_of(fun_q);
    flag_err_c  = (flags_c != 4'(4'b0001 << exp_class_c));
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      fun_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FUN_NOP;
      wait_cnt_q  <= '0;
      flag_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_class_q <= 2'b00;
      rsp_err_q   <= ERR_NONE;
      cmd_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            fun_q       <= req_fun;
            if (req_fun == FUN_NOP) begin
              // Illegal function: answer directly, ALU never driven.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_class_q <= 2'b00;
              rsp_err_q   <= ERR_FUN;
            end else if (req_fun == FUN_DIV && req_b == '0) begin
              // Divide by zero: answer directly, ALU never driven.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_class_q <= 2'b00;
              rsp_err_q   <= ERR_DIV0;
            end else begin
              state_q   <= S_ISSUE;
              alu_a_q   <= req_a;
              alu_b_q   <= req_b;
              alu_fun_q <= req_fun;
            end
          end else begin
            // Also raises ready on the first edge after reset.
            req_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          flag_err_q <= flag_err_c;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == CW'(RES_LAT - 1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out;
            rsp_class_q <= exp_class_c;
            rsp_err_q   <= flag_err_q ? ERR_FLAGS : ERR_NONE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= FUN_NOP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            cmd_count_q <= cmd_count_q + DW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_class = rsp_class_q;
  assign rsp_err   = rsp_err_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle-latency ALU model.
module tb_alu_cmd_sequencer;

  localparam int unsigned RES_LAT = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_fun;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        arith_flag;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_class;
  logic [1:0]  rsp_err;
  logic [15:0] cmd_count;

  logic        force_cmp;
  int          n_checks;
  int          n_fails;

  alu_cmd_sequencer #(.RES_LAT(RES_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_fun    (req_fun),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fun    (alu_fun),
    .alu_out    (alu_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_class  (rsp_class),
    .rsp_err    (rsp_err),
    .cmd_count  (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: registered result, combinational class flags.
  function automatic logic [15:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
    logic [15:0] r;
    case (f)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = 16'(a * b);
      4'd3:    r = (b == 16'd0) ? 16'd0 : a / b;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      4'd6:    r = a ^ b;
      4'd7:    r = ~a;
      4'd8:    r = ~(a & b);
      4'd9:    r = ~(a | b);
      4'd10:   r = {15'd0, a == b};
      4'd11:   r = {15'd0, a < b};
      4'd12:   r = {15'd0, a > b};
      4'd13:   r = a << b[3:0];
      4'd14:   r = a >> b[3:0];
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  initial alu_out = 16'd0;
  always @(posedge clk) alu_out <= alu_calc(alu_a, alu_b, alu_fun);

  assign arith_flag = (alu_fun <= 4'd3);
  assign logic_flag = (alu_fun >= 4'd4) && (alu_fun <= 4'd9);
  assign cmp_flag   = ((alu_fun >= 4'd10) && (alu_fun <= 4'd12)) || force_cmp;
  assign shift_flag = (alu_fun == 4'd13) || (alu_fun == 4'd14);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One command with rsp_ready=1; latency counted in negedge samples after the accept edge.
  task automatic run_cmd(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [15:0] exp_data,
                         input logic [1:0] exp_cls, input logic [1:0] exp_err,
                         input logic [15:0] exp_cnt);
    int lat;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_fun   = fun;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_err == 2'b01 || exp_err == 2'b10)
      check_eq("alu_fun_err_path", 32'(alu_fun), 32'hF);
    else
      check_eq("alu_fun_issue", 32'(alu_fun), 32'(fun));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
    check_eq("rsp_class", 32'(rsp_class), 32'(exp_cls));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check_eq("rsp_valid_done", 32'(rsp_valid), 32'd0);
    check_eq("cmd_count", 32'(cmd_count), 32'(exp_cnt));
    check_eq("alu_fun_idle", 32'(alu_fun), 32'hF);
  endtask

  initial begin
    int lat;
    n_checks  = 0;
    n_fails   = 0;
    force_cmp = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    req_fun   = 4'd0;
    rsp_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_alu_fun", 32'(alu_fun), 32'hF);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_cmd_count", 32'(cmd_count), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Add, div-by-zero, illegal fun, compare-equal
    run_cmd(4'h0, 16'h0003, 16'h0004, 3, 16'h0007, 2'b00, 2'b00, 16'd1);
    run_cmd(4'h3, 16'h0010, 16'h0000, 1, 16'h0000, 2'b00, 2'b10, 16'd2);
    run_cmd(4'hF, 16'h5555, 16'hAAAA, 1, 16'h0000, 2'b00, 2'b01, 16'd3);
    run_cmd(4'hA, 16'h1234, 16'h1234, 3, 16'h0001, 2'b10, 2'b00, 16'd4);

    // Flags not one-hot on an AND
    force_cmp = 1'b1;
    run_cmd(4'h4, 16'hF0F0, 16'hFF00, 3, 16'hF000, 2'b01, 2'b11, 16'd5);
    force_cmp = 1'b0;

    // Sub wrap, shift right, real divide
    run_cmd(4'h1, 16'h0005, 16'h0007, 3, 16'hFFFE, 2'b00, 2'b00, 16'd6);
    run_cmd(4'hE, 16'h8000, 16'h0004, 3, 16'h0800, 2'b11, 2'b00, 16'd7);
    run_cmd(4'h3, 16'd100,  16'd7,    3, 16'd14,   2'b00, 2'b00, 16'd8);

    // Response back-pressure with a pending request held valid
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a     = 16'h00FF;
    req_b     = 16'h0F0F;
    req_fun   = 4'h6;
    @(posedge clk);
    @(negedge clk);
    req_a = 16'h1111;
    req_b = 16'h2222;
    req_fun = 4'h0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("stall_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rsp_data", 32'(rsp_data), 32'h0FF0);
      check_eq("stall_rsp_class", 32'(rsp_class), 32'd1);
      check_eq("stall_rsp_err", 32'(rsp_err), 32'd0);
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      check_eq("stall_cmd_count", 32'(cmd_count), 32'd8);
      check_eq("stall_alu_fun", 32'(alu_fun), 32'hF);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("release_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("release_cmd_count", 32'(cmd_count), 32'd9);
    check_eq("release_req_ready", 32'(req_ready), 32'd1);
    check_eq("release_alu_fun", 32'(alu_fun), 32'hF);

    // Reset in the middle of WAIT
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'h0001;
    req_b     = 16'h0002;
    req_fun   = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("midwait_alu_fun", 32'(alu_fun), 32'h0);
    check_eq("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_cmd_count", 32'(cmd_count), 32'd0);
    check_eq("abort_alu_fun", 32'(alu_fun), 32'hF);
    check_eq("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_rst_rsp_data", 32'(rsp_data), 32'd0);
    run_cmd(4'h0, 16'h0003, 16'h0004, 3, 16'h0007, 2'b00, 2'b00, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
